// File: rtl/vmag_pkg.sv
// ---------------------------------------------------------------------------
// vmag_pkg
// Shared definitions for the vector-magnitude block and its helpers:
//   - vmag_state_t : control FSM states
//   - vmag_rw      : root width for W-bit components      (W+1)
//   - vmag_sum_w   : width of S = x^2 + y^2               (2W+1)
//   - vmag_rem_w   : width of the root remainder S - r^2  (W+2)
// ---------------------------------------------------------------------------
package vmag_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SQX,
      SQY,
      ROOT,
      DONE
   } vmag_state_t;

   function automatic int vmag_rw(input int w);
      return w + 1;
   endfunction

   function automatic int vmag_sum_w(input int w);
      return 2 * w + 1;
   endfunction

   function automatic int vmag_rem_w(input int w);
      return w + 2;
   endfunction

endpackage

// File: rtl/vmag_isqrt.sv
// ---------------------------------------------------------------------------
// vmag_isqrt
// Iterative restoring integer square root, one result bit per cycle, MSB
// first. A start pulse captures the operand; the root takes (SW+1)/2
// iteration cycles, after which done pulses for one cycle. root/rem then
// hold until the next start.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : capture operand and begin (restarts if already running)
//   operand   : SW-bit unsigned radicand
//   done      : one-cycle pulse, root/rem valid from this cycle on
//   root      : floor(sqrt(operand)), (SW+1)/2 bits
//   rem       : operand - root^2, (SW+1)/2 + 1 bits
// ---------------------------------------------------------------------------
module vmag_isqrt #(
   parameter int SW = 17
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [SW-1:0]          operand,
   output logic                   done,
   output logic [(SW+1)/2-1:0]    root,
   output logic [(SW+1)/2:0]      rem
);

   localparam int RTW  = (SW + 1) / 2;   // result bits
   localparam int OPW  = 2 * RTW;        // operand padded to whole bit-pairs
   localparam int REMW = RTW + 1;        // remainder never exceeds 2*root
   localparam int CW   = $clog2(RTW + 1);

   logic [OPW-1:0]    op_q;
   logic [REMW-1:0]   rem_q;
   logic [RTW-1:0]    root_q;
   logic [CW-1:0]     cnt_q;
   logic              run_q;
   logic              done_q;

   logic [REMW+1:0]   rem_try;
   logic [REMW+1:0]   trial;
   logic              fits;
   logic [REMW-1:0]   rem_d;

   // Bring down the next bit-pair and try subtracting (4*root + 1).
   always_comb begin
      rem_try = {rem_q, op_q[OPW-1 -: 2]};
      trial   = {1'b0, root_q, 2'b01};
      fits    = (rem_try >= trial);
      rem_d   = fits ? REMW'(rem_try - trial) : REMW'(rem_try);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            op_q   <= OPW'(operand);
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= CW'(RTW);
            run_q  <= 1'b1;
         end else if (run_q) begin
            op_q   <= op_q << 2;
            rem_q  <= rem_d;
            root_q <= {root_q[RTW-2:0], fits};
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done = done_q;
   assign root = root_q;
   assign rem  = rem_q;

endmodule

// File: rtl/vector_mag_seq.sv
// ---------------------------------------------------------------------------
// vector_mag_seq
// Sequential magnitude of an unsigned 2-D vector: S = x^2 + y^2 via a single
// shift-add unit (W cycles per square), then the integer square root of S via
// vmag_isqrt, optionally rounded to nearest. Result latency is 3W+2 edges
// from the accepting edge.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   in_x, in_y          : W-bit unsigned components
//   in_round            : 0 = floor root, 1 = round-to-nearest root
//   out_valid/out_ready : result handshake (valid only in DONE)
//   out_root            : root of S (W+1 bits), 0 when not valid
//   out_rem             : S - floor_root^2 (W+2 bits), 0 when not valid
//   out_sumsq           : S (2W+1 bits), 0 when not valid
//   busy                : high in every state but IDLE
// ---------------------------------------------------------------------------
module vector_mag_seq
   import vmag_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_x,
   input  logic [W-1:0]             in_y,
   input  logic                     in_round,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [vmag_rw(W)-1:0]    out_root,
   output logic [vmag_rem_w(W)-1:0] out_rem,
   output logic [vmag_sum_w(W)-1:0] out_sumsq,
   output logic                     busy
);

   localparam int RW    = vmag_rw(W);
   localparam int SUM_W = vmag_sum_w(W);
   localparam int REM_W = vmag_rem_w(W);
   localparam int CW    = $clog2(W);

   vmag_state_t      state_q, state_d;

   logic [SUM_W-1:0] mcand_q;    // multiplicand, shifted left each cycle
   logic [W-1:0]     mplier_q;   // multiplier, shifted right each cycle
   logic [W-1:0]     y_q;
   logic [SUM_W-1:0] sum_q;
   logic             round_q;
   logic [CW-1:0]    cnt_q;

   logic [SUM_W-1:0] sum_d;
   logic             cnt_last;
   logic             sqrt_start;
   logic             sqrt_done;
   logic [RW-1:0]    sqrt_root;
   logic [REM_W-1:0] sqrt_rem;
   logic             round_up;
   logic [RW-1:0]    root_fin;

   assign sum_d    = sum_q + (mplier_q[0] ? mcand_q : '0);
   assign cnt_last = (cnt_q == CW'(W - 1));
   // The root unit captures S on the same edge the last y partial product
   // folds in, so it takes the combinational sum rather than sum_q.
   assign sqrt_start = (state_q == SQY) && cnt_last;

   // NOTE: state_d gets a default before the case so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = SQX;
         SQX:     if (cnt_last)  state_d = SQY;
         SQY:     if (cnt_last)  state_d = ROOT;
         ROOT:    if (sqrt_done) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every datapath register is an ordinary flop and is cleared on reset, so the block restarts from a known state.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         y_q      <= '0;
         sum_q    <= '0;
         round_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mcand_q  <= SUM_W'(in_x);
                  mplier_q <= in_x;
                  y_q      <= in_y;
                  round_q  <= in_round;
                  sum_q    <= '0;
                  cnt_q    <= '0;
               end
            end
            SQX, SQY: begin
               sum_q    <= sum_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_last) begin
                  cnt_q <= '0;
                  // Reload the shared shift-add unit with y for the second square.
                  if (state_q == SQX) begin
                     mcand_q  <= SUM_W'(y_q);
                     mplier_q <= y_q;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   vmag_isqrt #(
      .SW (SUM_W)
   ) u_isqrt (
      .clk     (clk),
      .rst     (rst),
      .start   (sqrt_start),
      .operand (sum_d),
      .done    (sqrt_done),
      .root    (sqrt_root),
      .rem     (sqrt_rem)
   );

   // Nearest integer: S - r^2 > r  <=>  S > (r + 1/2)^2 for integers.
   assign round_up = round_q && (sqrt_rem > REM_W'(sqrt_root));
   assign root_fin = sqrt_root + RW'(round_up);

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign out_root  = out_valid ? root_fin : '0;
   assign out_rem   = out_valid ? sqrt_rem : '0;
   assign out_sumsq = out_valid ? sum_q    : '0;

endmodule

// File: tb/tb_vector_mag_seq.sv
// ---------------------------------------------------------------------------
// tb_vector_mag_seq
// Self-checking bench for vector_mag_seq (W=8): directed corner vectors,
// back-pressure, mid-operation reset, then randomized operands, each compared
// against an arithmetic reference of magnitude, remainder and rounding.
// ---------------------------------------------------------------------------
module tb_vector_mag_seq;

   localparam int W     = 8;
   localparam int RW    = W + 1;
   localparam int REM_W = W + 2;
   localparam int SUM_W = 2 * W + 1;
   localparam int LAT   = 3 * W + 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_x = '0;
   logic [W-1:0]     in_y = '0;
   logic             in_round = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [RW-1:0]    out_root;
   logic [REM_W-1:0] out_rem;
   logic [SUM_W-1:0] out_sumsq;
   logic             busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vector_mag_seq #(
      .W (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_round  (in_round),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_root  (out_root),
      .out_rem   (out_rem),
      .out_sumsq (out_sumsq),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: floor root by search, remainder, optional round-to-nearest.
   function automatic void ref_model(input int x, input int y, input bit rnd,
                                     output int s, output int root, output int rem);
      int r;
      s = x * x + y * y;
      r = 0;
      while ((r + 1) * (r + 1) <= s) r++;
      rem  = s - r * r;
      root = (rnd && rem > r) ? r + 1 : r;
   endfunction

   task automatic run_op(input int x, input int y, input bit rnd, input int hold);
      int s, e_root, e_rem, k;
      logic [RW-1:0]    snap_root;
      logic [REM_W-1:0] snap_rem;
      logic [SUM_W-1:0] snap_sum;
      ref_model(x, y, rnd, s, e_root, e_rem);

      k = 0;
      while (!in_ready && k < 100) begin
         @(posedge clk); #1; k++;
      end
      check("ready_before_op", 64'(in_ready), 64'(1));

      in_x = W'(x); in_y = W'(y); in_round = rnd; in_valid = 1'b1;
      @(posedge clk); #1;
      // Scramble inputs after accept; the in-flight result must not change.
      in_valid = 1'b0; in_x = W'($urandom); in_y = W'($urandom); in_round = 1'($urandom);
      check("busy_after_accept", 64'(busy), 64'(1));
      check("no_ready_when_busy", 64'(in_ready), 64'(0));
      check("sumsq_zero_invalid", 64'(out_sumsq), 64'(0));

      k = 0;
      while (!out_valid && k < 100) begin
         in_valid = 1'($urandom);
         in_x = W'($urandom); in_y = W'($urandom); in_round = 1'($urandom);
         @(posedge clk); #1; k++;
         if (!out_valid && k == 2 * W)
            check("root_zero_invalid", 64'(out_root), 64'(0));
      end
      in_valid = 1'b0;
      check("latency", 64'(k), 64'(LAT));
      check("root", 64'(out_root), 64'(e_root));
      check("rem", 64'(out_rem), 64'(e_rem));
      check("sumsq", 64'(out_sumsq), 64'(s));

      snap_root = out_root; snap_rem = out_rem; snap_sum = out_sumsq;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'($urandom);
         @(posedge clk); #1;
         check("hold_valid", 64'(out_valid), 64'(1));
         check("hold_root", 64'(out_root), 64'(e_root));
         check("hold_stable", 64'({out_rem, out_sumsq}), 64'({snap_rem, snap_sum}));
      end
      if (hold > 0) check("hold_root_snap", 64'(out_root), 64'(snap_root));
      in_valid = 1'b0;

      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("valid_drop", 64'(out_valid), 64'(0));
      check("ready_after_done", 64'(in_ready), 64'(1));
   endtask

   initial begin
      bit seen;
      int rx, ry, rh;
      bit rr;

      // Power-on reset.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_outputs", 64'({out_root, out_rem, out_sumsq}), 64'(0));

      // Directed corners.
      run_op(3, 4, 1'b0, 0);
      run_op(255, 255, 1'b0, 0);
      run_op(255, 255, 1'b1, 0);
      run_op(7, 8, 1'b1, 10);      // back-pressure with ignored in_valid pulses
      run_op(7, 8, 1'b0, 0);
      run_op(1, 1, 1'b1, 0);       // rem == r must not round up
      run_op(0, 0, 1'b0, 0);

      // Reset in the middle of ROOT aborts without a result.
      in_x = 8'd200; in_y = 8'd100; in_round = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2 * W + 3) @(posedge clk);
      #1;
      check("busy_in_root", 64'(busy), 64'(1));
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;   // rst wins over both
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("abort_in_ready", 64'(in_ready), 64'(1));
      check("abort_busy", 64'(busy), 64'(0));
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_valid", 64'(seen), 64'(0));
      run_op(5, 12, 1'b0, 0);

      // Randomized operands.
      for (int i = 0; i < 24; i++) begin
         rx = int'($urandom_range(0, 255));
         ry = int'($urandom_range(0, 255));
         rr = 1'($urandom);
         rh = int'($urandom_range(0, 3));
         run_op(rx, ry, rr, rh);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vector_mag_seq.md
VECTOR_MAG_SEQ -- requirements
Module: vector_mag_seq

Interface
REQ-001 The module SHALL expose parameter W, default 8, meaning the unsigned width of each input component (legal range 2..16).
REQ-002 The module SHALL expose parameter RW = W+1, derived and not overridable, meaning the result root width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-007 The module SHALL have port in_x, input, W bits: unsigned x component.
REQ-008 The module SHALL have port in_y, input, W bits: unsigned y component.
REQ-009 The module SHALL have port in_round, input, 1 bit: 0 selects a floor root, 1 selects a round-to-nearest root; sampled on accept.
REQ-010 The module SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The module SHALL have port out_root, output, RW bits: the root of x^2+y^2, floor or rounded.
REQ-013 The module SHALL have port out_rem, output, W+2 bits: S minus floor_root^2.
REQ-014 The module SHALL have port out_sumsq, output, 2W+1 bits: S = x^2+y^2.
REQ-015 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, SQX, SQY, ROOT and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE, and a transfer SHALL occur on a rising edge with in_valid&&in_ready.
REQ-018 On accept, the block SHALL register x, y and in_round, and the FSM SHALL move IDLE->SQX.
REQ-019 SQX SHALL compute x*x by shift-add over exactly W cycles, then move to SQY.
REQ-020 SQY SHALL compute y*y over exactly W cycles, accumulate into a (2W+1)-bit S with no truncation, then move to ROOT.
REQ-021 ROOT SHALL compute the bitwise restoring integer square root over exactly RW cycles, one result bit per cycle from MSB down, then move to DONE.
REQ-022 out_valid SHALL rise exactly 3W+2 rising edges after the accepting edge (26 for W=8).
REQ-023 out_rem SHALL equal S - r^2, where r is the floor root, regardless of in_round.
REQ-024 With round=1, out_root SHALL equal r+1 when out_rem > r, else r; no overflow is possible in RW bits.
REQ-025 In DONE, out_valid SHALL be 1, and out_root/out_rem/out_sumsq SHALL hold stable until out_valid&&out_ready.
REQ-026 DONE with out_ready=1 SHALL move to IDLE on that edge, and in_ready SHALL be 1 on the next cycle; there is no same-cycle re-accept.
REQ-027 DONE with out_ready=0 SHALL hold indefinitely.
REQ-028 in_x, in_y and in_round changing after accept SHALL NOT affect the in-flight result.
REQ-029 in_valid in any non-IDLE state SHALL be ignored; no queueing.
REQ-030 Input (0,0) SHALL take the full latency and yield root 0, rem 0, sumsq 0.
REQ-031 out_root, out_rem and out_sumsq SHALL read 0 whenever out_valid=0.

Reset
REQ-032 With rst=1 on a rising edge, the FSM SHALL go to IDLE, and all datapath registers and outputs SHALL clear to 0 (in_ready=1, out_valid=0, busy=0 on the following cycle).
REQ-033 rst asserted mid-operation, in any state, SHALL abort the computation with no out_valid pulse.
REQ-034 rst SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-035 The FSM state enum and the width helper constants (RW, SUM_W=2W+1, REM_W=W+2) SHALL live in shared package vmag_pkg.
REQ-036 The iterative root SHALL be the sub-module vmag_isqrt, with parameter SW and a start/done handshake, reusable by other blocks.
REQ-037 The squaring SHALL use a single shared shift-add unit with no hardware multiplier, and the root SHALL use no multiplier.

Verification
REQ-038 W=8, (3,4), round=0 -> out_root=5, out_rem=0, out_sumsq=25, out_valid at edge 26.
REQ-039 W=8, (255,255) -> sumsq=130050, rem=450, root=360 with round=0 and 361 with round=1.
REQ-040 W=8, (7,8), round=1 -> sumsq=113, rem=13, root=11; with round=0 -> root=10.
REQ-041 W=8, (1,1), round=1 -> root=1, rem=1 (boundary rem==r does not round up); (0,0) -> all zeros.
REQ-042 Back-pressure: out_ready=0 for 10 cycles in DONE -> outputs stable; in_valid pulses ignored; accept on the cycle after out_ready=1.
REQ-043 rst=1 during ROOT -> IDLE next cycle, no out_valid; the next (5,12) returns root 13.
